// File: rtl/instr_prefetch_queue.sv
// ----------------------------------------------------------------------------
// instr_prefetch_queue
//
// Instruction prefetch stage sitting between a synchronous program memory
// and the fetch/decode controller. Consecutive program words are read ahead
// of demand and buffered, together with their addresses, in a small circular
// queue. Words are handed downstream over a valid/ready handshake. A redirect
// (jump or reset vector) flushes the queue and restarts fetching.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        asynchronous active-low reset (0 = in reset)
//   mem_addr     program memory read address (current fetch pc)
//   mem_rd       read strobe; mem_data is valid one cycle later
//   mem_data     program memory read data
//   redirect     flush queue and restart fetching at redirect_pc
//   redirect_pc  new fetch address
//   halt         stop issuing new reads
//   out_valid    out_data/out_pc hold a valid word
//   out_ready    consumer accepts the word when out_valid && out_ready
//   out_data     instruction word at the head of the queue
//   out_pc       address of out_data
//   out_count    number of words currently queued
//
// Optional feature macro: PREFETCH_BYPASS_EN
//   When defined, a response arriving at an empty queue is presented on
//   out_* in the same cycle (and skips the queue if it is taken at once).
//   When undefined, out_* are driven only from registered queue state.
// ----------------------------------------------------------------------------
module instr_prefetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [AW-1:0]          mem_addr,
    output logic                   mem_rd,
    input  logic [DW-1:0]          mem_data,
    input  logic                   redirect,
    input  logic [AW-1:0]          redirect_pc,
    input  logic                   halt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DW-1:0]          out_data,
    output logic [AW-1:0]          out_pc,
    output logic [$clog2(DEPTH):0] out_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic          inflight_q, inflight_d;
    logic [AW-1:0] inflight_pc_q, inflight_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [DW-1:0] data_mem_q [DEPTH];
    logic [AW-1:0] pc_mem_q   [DEPTH];

    logic          q_empty;
    logic          resp_live;
    logic          push;
    logic          pop;
    logic [CW:0]   credit_used;
    logic          issue;

    assign q_empty   = (count_q == '0);
    // A response is dropped when a redirect lands in the cycle it returns.
    assign resp_live = inflight_q && !redirect;

    // Words already queued plus the one in flight must leave room; a pop
    // happening this cycle is deliberately not counted as free space.
    assign credit_used = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    // reset gates the strobe so no read is requested while held in reset.
    assign issue  = reset && !halt && !redirect && (credit_used < (CW+1)'(DEPTH));
    assign mem_rd   = issue;
    assign mem_addr = fetch_pc_q;

`ifdef PREFETCH_BYPASS_EN
    logic bypass;
    assign bypass    = q_empty && resp_live;
    assign out_valid = !q_empty || bypass;
    assign out_data  = !q_empty ? data_mem_q[rd_ptr_q] : (bypass ? mem_data    : '0);
    assign out_pc    = !q_empty ? pc_mem_q[rd_ptr_q]   : (bypass ? inflight_pc_q : '0);
    // A bypassed word taken in the same cycle never enters the queue.
    assign push      = resp_live && !(bypass && out_ready);
`else
    assign out_valid = !q_empty;
    assign out_data  = q_empty ? '0 : data_mem_q[rd_ptr_q];
    assign out_pc    = q_empty ? '0 : pc_mem_q[rd_ptr_q];
    assign push      = resp_live;
`endif

    // Only words actually held in the queue are popped from it.
    assign pop       = !q_empty && out_ready;
    assign out_count = count_q;

    // NOTE: every always_comb target gets a default first so no latch is inferred.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (issue) begin
            fetch_pc_d    = fetch_pc_q + AW'(1);
            inflight_pc_d = fetch_pc_q;
        end

        if (redirect) begin
            // Redirect overrides any push/pop/issue in the same cycle.
            fetch_pc_d = redirect_pc;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    // NOTE: queue storage is not reset; entries are only observed once count marks them valid.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= mem_data;
            pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
module tb_instr_prefetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_data = 32'd0;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] out_pc;
    logic [2:0]  out_count;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_pc = 16'd0;
    int          consumed = 0;

    instr_prefetch_queue dut (
        .clk         (clk),
        .reset       (reset),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_pc      (out_pc),
        .out_count   (out_count)
    );

    always #5 clk = ~clk;

    // Program memory: word at address a holds a*3, returned one cycle after the read.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= 32'(mem_addr) * 32'd3;
    end

    function automatic logic [31:0] exp_data(input logic [15:0] pc);
        return 32'(pc) * 32'd3;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Score a handshake happening at the coming edge, then advance one cycle.
    task automatic tick();
        if (out_valid && out_ready) begin
            check("seq_pc", 32'(out_pc), 32'(exp_pc));
            check("seq_data", out_data, exp_data(exp_pc));
            exp_pc = exp_pc + 16'd1;
            consumed++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; redirect = 1'b0; halt = 1'b0; out_ready = 1'b0; redirect_pc = 16'h0;

        // Reset held with random inputs: all outputs stay zero.
        for (int i = 0; i < 6; i++) begin
            redirect    = 1'($urandom);
            halt        = 1'($urandom);
            out_ready   = 1'($urandom);
            redirect_pc = 16'($urandom);
            @(negedge clk);
            check("rst_mem_rd",   32'(mem_rd),    32'd0);
            check("rst_mem_addr", 32'(mem_addr),  32'd0);
            check("rst_valid",    32'(out_valid), 32'd0);
            check("rst_data",     out_data,       32'd0);
            check("rst_pc",       32'(out_pc),    32'd0);
            check("rst_count",    32'(out_count), 32'd0);
        end

        // Release: reads 0..3 issue back to back, then the credit limit stalls.
        redirect = 1'b0; halt = 1'b0; out_ready = 1'b0; redirect_pc = 16'h0;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("fill_rd",   32'(mem_rd),   32'd1);
            check("fill_addr", 32'(mem_addr), 32'(i));
            cycle();
        end
        check("stall_rd",    32'(mem_rd),    32'd0);
        check("stall_addr",  32'(mem_addr),  32'd4);
        check("stall_count", 32'(out_count), 32'd3);
        cycle();

        // Backpressure: full queue, head stable, no reads.
        for (int i = 0; i < 3; i++) begin
            check("full_count", 32'(out_count), 32'd4);
            check("full_rd",    32'(mem_rd),    32'd0);
            check("full_valid", 32'(out_valid), 32'd1);
            check("full_pc",    32'(out_pc),    32'd0);
            check("full_data",  out_data,       32'd0);
            cycle();
        end

        // Drain in order, then keep streaming without gaps.
        out_ready = 1'b1;
        exp_pc = 16'd0; consumed = 0;
        for (int i = 0; i < 40 && consumed < 16; i++) begin
            tick();
            check("stream_valid", 32'(out_valid), 32'd1);
        end
        check("stream_consumed", 32'(consumed), 32'd16);

        // Redirect with a read in flight: stale word must never appear.
        check("pre_redir_rd", 32'(mem_rd), 32'd1);
        redirect = 1'b1; redirect_pc = 16'h0100;
        #1;
        check("redir_rd", 32'(mem_rd), 32'd0);
        tick();
        redirect = 1'b0; out_ready = 1'b0;
        #1;
        check("redir_count", 32'(out_count), 32'd0);
        check("redir_valid", 32'(out_valid), 32'd0);
        check("redir_rd1",   32'(mem_rd),    32'd1);
        check("redir_addr",  32'(mem_addr),  32'h0100);
        cycle();
`ifdef PREFETCH_BYPASS_EN
        check("lat1_valid", 32'(out_valid), 32'd1);
        check("lat1_pc",    32'(out_pc),    32'h0100);
        check("lat1_data",  out_data,       32'h0300);
`else
        check("lat1_valid", 32'(out_valid), 32'd0);
`endif
        cycle();
        check("lat2_valid", 32'(out_valid), 32'd1);
        check("lat2_pc",    32'(out_pc),    32'h0100);
        check("lat2_data",  out_data,       32'h0300);
        check("lat2_count", 32'(out_count), 32'd1);
        out_ready = 1'b1;
        exp_pc = 16'h0100; consumed = 0;
        for (int i = 0; i < 30 && consumed < 6; i++) tick();
        check("redir_consumed", 32'(consumed), 32'd6);

        // Wrap + halt: two reads from 0xFFFE, halt, resume at 0x0000.
        out_ready = 1'b0; redirect = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect = 1'b0;
        #1;
        check("wrap_addr0", 32'(mem_addr), 32'hFFFE);
        check("wrap_rd0",   32'(mem_rd),   32'd1);
        cycle();
        check("wrap_addr1", 32'(mem_addr), 32'hFFFF);
        check("wrap_rd1",   32'(mem_rd),   32'd1);
        cycle();
        halt = 1'b1;
        #1;
        check("halt_rd",   32'(mem_rd),   32'd0);
        check("halt_addr", 32'(mem_addr), 32'h0000);
        cycle(); cycle(); cycle();
        check("halt_count", 32'(out_count), 32'd2);
        check("halt_rd2",   32'(mem_rd),    32'd0);
        check("halt_pc",    32'(out_pc),    32'hFFFE);
        check("halt_data",  out_data,       32'h0002FFFA);
        out_ready = 1'b1;
        exp_pc = 16'hFFFE; consumed = 0;
        for (int i = 0; i < 10 && consumed < 2; i++) tick();
        check("halt_consumed", 32'(consumed),  32'd2);
        check("halt_empty",    32'(out_count), 32'd0);
        check("halt_valid",    32'(out_valid), 32'd0);
        halt = 1'b0;
        #1;
        check("resume_addr", 32'(mem_addr), 32'h0000);
        check("resume_rd",   32'(mem_rd),   32'd1);
        for (int i = 0; i < 20 && consumed < 6; i++) tick();
        check("resume_consumed", 32'(consumed), 32'd6);

        // Build count=2, then push and pop together for 10 cycles.
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_count == 3'd2) break;
            cycle();
        end
        check("pp_fill", 32'(out_count), 32'd2);
        out_ready = 1'b1;
        consumed = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("pp_count", 32'(out_count), 32'd2);
        end
        check("pp_consumed", 32'(consumed), 32'd10);

        // Reset mid-operation clears everything at once.
        check("pre_rst_rd", 32'(mem_rd), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_rd",    32'(mem_rd),    32'd0);
        check("mid_rst_count", 32'(out_count), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_addr",  32'(mem_addr),  32'd0);
        cycle();
        halt = 1'b1;
        reset = 1'b1;
        cycle();
        check("post_rst_count", 32'(out_count), 32'd0);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_addr",  32'(mem_addr),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
